// File: rtl/sync_down_counter.sv
// Cascadable synchronous binary down-counter with a borrow output for ripple chaining.
// Optional auto-reload from the last loaded value and a sticky underflow flag.
module sync_down_counter #(
    parameter int WIDTH       = 4,
    parameter int AUTO_RELOAD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             enp,
    input  logic             ent,
    input  logic             uf_clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             uf,
    output logic [WIDTH-1:0] reload_val
);

    logic             at_zero;
    logic             count_en;
    logic             underflow;
    logic [WIDTH-1:0] wrap_val;
    logic [WIDTH-1:0] q_dec;

    always_comb begin
        at_zero   = (q == '0);
        count_en  = enp & ent;
        // load and clear both pre-empt the count, so neither can underflow
        underflow = ~clr & ~ld & count_en & at_zero;
        wrap_val  = '1;
        if (AUTO_RELOAD != 0) begin
            wrap_val = reload_val;
        end
        q_dec     = q - WIDTH'(1);
    end

    assign tc = ent & at_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            q          <= '0;
            reload_val <= '0;
            uf         <= 1'b0;
        end else begin
            if (clr) begin
                q <= '0;
            end else if (ld) begin
                q          <= d;
                reload_val <= d;
            end else if (count_en) begin
                q <= at_zero ? wrap_val : q_dec;
            end

            if (underflow) begin
                uf <= 1'b1;
            end else if (uf_clr) begin
                uf <= 1'b0;
            end
        end
    end

endmodule
